// File: rtl/fetch_align_queue_pkg.sv
// -----------------------------------------------------------------------------
// fetch_align_queue_pkg
// Shared types and constants for the halfword fetch queue and its consumers.
//   halfword_t      : one 16-bit parcel of the instruction stream
//   FAQ_DEPTH_HW    : default queue capacity in halfwords
//   NOP_INSTR       : instruction presented while nothing valid is at the head
//   fetch_out_type  : instruction/PC/compressed bundle for the IF/ID register
//   is_compressed() : RV32C length decode of the first halfword of an instruction
// -----------------------------------------------------------------------------
package fetch_align_queue_pkg;

  typedef logic [15:0] halfword_t;

  localparam int          FAQ_DEPTH_HW = 8;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        compressed;
  } fetch_out_type;

  // Only the two lowest bits decide the length: 2'b11 starts a 32-bit instruction.
  function automatic logic is_compressed(input halfword_t hw);
    return hw[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/fetch_align_queue_ring.sv
// -----------------------------------------------------------------------------
// hw_ring_buffer
// Generic ring of DEPTH halfwords accepting 0/1/2 entries and releasing 0/1/2
// entries per cycle. The caller guarantees it never overfills or over-pops.
//   clk, reset           : clock, asynchronous active-high reset
//   clear                : synchronous empty (pointers and count return to 0)
//   push_cnt             : number of halfwords written this cycle (0..2)
//   push_hw0, push_hw1   : first and second halfword to write, in that order
//   pop_cnt              : number of halfwords released this cycle (0..2)
//   count                : occupied entries
//   peek0, peek1         : oldest and second-oldest entries
// -----------------------------------------------------------------------------
module hw_ring_buffer
  import fetch_align_queue_pkg::*;
#(
  parameter int DEPTH = FAQ_DEPTH_HW
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic [1:0]             push_cnt,
  input  halfword_t              push_hw0,
  input  halfword_t              push_hw1,
  input  logic [1:0]             pop_cnt,
  output logic [$clog2(DEPTH):0] count,
  output halfword_t              peek0,
  output halfword_t              peek1
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // DEPTH is a power of two, so pointer arithmetic wraps for free.
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  halfword_t     mem [DEPTH];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(pop_cnt);
      tail  <= tail + PW'(push_cnt);
      count <= count + CW'(push_cnt) - CW'(pop_cnt);
    end
  end

  // NOTE: the storage array has no reset; an entry is only ever read after it
  // has been written, because count gates every use of the peeked data.
  always_ff @(posedge clk) begin
    if (push_cnt != 2'd0) mem[tail] <= push_hw0;
    if (push_cnt == 2'd2) mem[tail + PW'(1)] <= push_hw1;
  end

  assign peek0 = mem[head];
  assign peek1 = mem[head + PW'(1)];

endmodule

// File: rtl/fetch_align_queue.sv
// -----------------------------------------------------------------------------
// fetch_align_queue
// Fetch buffer between program memory and IF/ID. Aligned 32-bit fetch words are
// split into halfwords; whole RV32IC instructions (16 or 32 bit, possibly
// straddling two fetch words) are presented at the head with their PC.
//   clk, reset                     : clock, asynchronous active-high reset
//   in_valid / in_ready / in_word  : fetch word handshake, [15:0] = lower address
//   flush / flush_pc               : redirect; drop contents, restart at flush_pc
//   out_valid / out_ready          : instruction handshake towards IF/ID
//   out_instr / out_pc             : head instruction (16-bit zero-extended), PC
//   out_compressed                 : head instruction is 16-bit
//   level                          : occupied halfword count
// -----------------------------------------------------------------------------
module fetch_align_queue
  import fetch_align_queue_pkg::*;
#(
  parameter int                DEPTH_HW = FAQ_DEPTH_HW,
  parameter int                PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [31:0]               in_word,
  input  logic                      flush,
  input  logic [PC_WIDTH-1:0]       flush_pc,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [31:0]               out_instr,
  output logic [PC_WIDTH-1:0]       out_pc,
  output logic                      out_compressed,
  output logic [$clog2(DEPTH_HW):0] level
);

  localparam int LW = $clog2(DEPTH_HW) + 1;
  // Highest level at which a one- or two-halfword push still fits.
  localparam logic [LW-1:0] MAX_LVL_ONE = LW'(DEPTH_HW - 1);
  localparam logic [LW-1:0] MAX_LVL_TWO = LW'(DEPTH_HW - 2);

  logic [PC_WIDTH-1:0] head_pc;
  logic                skip_lo;   // drop in_word[15:0] of the next accepted word
  halfword_t           hw0;
  halfword_t           hw1;
  logic                head_compressed;
  logic                push;
  logic                pop;
  logic [1:0]          push_cnt;
  logic [1:0]          pop_cnt;
  logic                unused_flush_lsb;

  assign unused_flush_lsb = flush_pc[0];

  // Flush blocks intake in its own cycle so nothing lands in the stale stream.
  assign in_ready = !flush && (skip_lo ? (level <= MAX_LVL_ONE) : (level <= MAX_LVL_TWO));
  assign push     = in_valid && in_ready;
  assign push_cnt = !push ? 2'd0 : (skip_lo ? 2'd1 : 2'd2);

  assign head_compressed = is_compressed(hw0);
  // level>=2 always completes the head; level==1 only for a 16-bit head.
  assign out_valid = (level >= LW'(2)) || ((level == LW'(1)) && head_compressed);
  assign pop       = out_valid && out_ready && !flush;
  assign pop_cnt   = !pop ? 2'd0 : (head_compressed ? 2'd1 : 2'd2);

  hw_ring_buffer #(
    .DEPTH (DEPTH_HW)
  ) u_ring (
    .clk      (clk),
    .reset    (reset),
    .clear    (flush),
    .push_cnt (push_cnt),
    .push_hw0 (skip_lo ? in_word[31:16] : in_word[15:0]),
    .push_hw1 (in_word[31:16]),
    .pop_cnt  (pop_cnt),
    .count    (level),
    .peek0    (hw0),
    .peek1    (hw1)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_pc <= RESET_PC;
      skip_lo <= 1'b0;
    end else if (flush) begin
      // A redirect into the upper half of a word skips that word's lower half.
      head_pc <= {flush_pc[PC_WIDTH-1:1], 1'b0};
      skip_lo <= flush_pc[1];
    end else begin
      if (pop)  head_pc <= head_pc + (head_compressed ? PC_WIDTH'(2) : PC_WIDTH'(4));
      if (push) skip_lo <= 1'b0;
    end
  end

  assign out_instr      = !out_valid ? NOP_INSTR
                        : (head_compressed ? {16'h0000, hw0} : {hw1, hw0});
  assign out_pc         = head_pc;
  assign out_compressed = head_compressed;

endmodule

// File: tb/tb_fetch_align_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_align_queue
// Scoreboard bench: issuing a fetch word runs it through a reference parser
// (halfword list -> instruction list with PCs) that fills the expected queue;
// a negedge monitor compares the head, level and handshakes every cycle and
// pops the expected queue on each accepted instruction.
// -----------------------------------------------------------------------------
module tb_fetch_align_queue;
  import fetch_align_queue_pkg::*;

  localparam int          DEPTH    = 8;
  localparam int          PCW      = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic            clk;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_word;
  logic            flush;
  logic [PCW-1:0]  flush_pc;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_instr;
  logic [PCW-1:0]  out_pc;
  logic            out_compressed;
  logic [3:0]      level;

  fetch_align_queue #(
    .DEPTH_HW (DEPTH),
    .PC_WIDTH (PCW),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_word        (in_word),
    .flush          (flush),
    .flush_pc       (flush_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_compressed (out_compressed),
    .level          (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %08h, expected %08h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0]   w_q[$];     // words issued, not yet accepted by the DUT
  halfword_t     pend[$];    // parsed stream tail that is not a whole instruction yet
  fetch_out_type exp_q[$];   // whole instructions expected at the output, in order
  int            exp_level;  // halfwords the DUT should hold
  bit            skip_dut;   // next accepted word contributes only its upper half
  bit            skip_gen;   // next issued word contributes only its upper half
  logic [31:0]   gen_pc;     // PC of the first halfword in pend
  bit            mon_en = 1'b0;

  task automatic model_reset(input logic [31:0] pc, input bit skip);
    w_q.delete();
    pend.delete();
    exp_q.delete();
    exp_level = 0;
    skip_dut  = skip;
    skip_gen  = skip;
    gen_pc    = pc;
  endtask

  task automatic add_hw(input halfword_t h);
    fetch_out_type e;
    pend.push_back(h);
    forever begin
      if (pend.size() == 0) break;
      if (pend[0][1:0] != 2'b11) begin
        e.instr = {16'h0000, pend[0]}; e.pc = gen_pc; e.compressed = 1'b1;
        exp_q.push_back(e);
        gen_pc = gen_pc + 32'd2;
        void'(pend.pop_front());
      end else if (pend.size() >= 2) begin
        e.instr = {pend[1], pend[0]}; e.pc = gen_pc; e.compressed = 1'b0;
        exp_q.push_back(e);
        gen_pc = gen_pc + 32'd4;
        void'(pend.pop_front());
        void'(pend.pop_front());
      end else break;
    end
  endtask

  task automatic issue(input logic [31:0] w);
    w_q.push_back(w);
    if (!skip_gen) add_hw(w[15:0]);
    skip_gen = 1'b0;
    add_hw(w[31:16]);
  endtask

  function automatic logic [31:0] rand_word();
    halfword_t h0, h1;
    h0 = halfword_t'($urandom);
    h1 = halfword_t'($urandom);
    if ($urandom_range(0, 1) == 1) h0[1:0] = 2'b11; else if (h0[1:0] == 2'b11) h0[1:0] = 2'b01;
    if ($urandom_range(0, 1) == 1) h1[1:0] = 2'b11; else if (h1[1:0] == 2'b11) h1[1:0] = 2'b10;
    return {h1, h0};
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin : monitor
    bit exp_v;
    int need;
    int need_in;
    if (mon_en && !reset) begin
      exp_v = 1'b0;
      need  = 2;
      if (exp_q.size() > 0) begin
        need  = exp_q[0].compressed ? 1 : 2;
        exp_v = (exp_level >= need);
      end
      need_in = skip_dut ? 1 : 2;
      check("level", 32'(level), exp_level);
      check("in_ready", 32'(in_ready), 32'(!flush && (DEPTH - exp_level >= need_in)));
      check("out_valid", 32'(out_valid), 32'(exp_v));
      if (exp_q.size() > 0) check("out_pc", out_pc, exp_q[0].pc);
      else                  check("out_pc", out_pc, gen_pc);
      if (exp_v) begin
        check("out_instr", out_instr, exp_q[0].instr);
        check("out_compressed", 32'(out_compressed), 32'(exp_q[0].compressed));
        if (out_ready && !flush) begin
          exp_level -= need;
          void'(exp_q.pop_front());
        end
      end else begin
        check("out_instr_nop", out_instr, NOP_INSTR);
      end
    end
  end

  // ---------------- driver ----------------
  // Entered and left at posedge+1; the DUT samples at the posedge in between.
  task automatic cycle(input bit do_flush, input logic [31:0] fpc, input bit want_push, input bit rdy);
    bit acc;
    flush     = do_flush;
    flush_pc  = fpc;
    out_ready = rdy;
    in_valid  = want_push && !do_flush && (w_q.size() > 0);
    in_word   = (w_q.size() > 0) ? w_q[0] : 32'h0;
    @(negedge clk);
    acc = in_valid && in_ready;
    @(posedge clk);
    #1;
    if (do_flush) begin
      model_reset({fpc[31:1], 1'b0}, fpc[1]);
    end else if (acc) begin
      exp_level += skip_dut ? 1 : 2;
      skip_dut = 1'b0;
      void'(w_q.pop_front());
    end
    flush    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic push_all(input bit rdy);
    for (int i = 0; i < 64 && w_q.size() > 0; i++) cycle(1'b0, 32'h0, 1'b1, rdy);
    check("push_all_accepted", w_q.size(), 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && (w_q.size() > 0 || exp_q.size() > 0); i++)
      cycle(1'b0, 32'h0, 1'b1, 1'b1);
    check("drain_empty", exp_q.size() + w_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rdy_pct;
    logic [31:0] fpc;
    reset = 1'b1; in_valid = 1'b0; in_word = '0; flush = 1'b0; flush_pc = '0; out_ready = 1'b0;
    model_reset(RESET_PC, 1'b0);
    #7;
    check("rst_level", 32'(level), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_instr", out_instr, NOP_INSTR);
    check("rst_out_pc", out_pc, RESET_PC);
    @(posedge clk); #1;
    reset  = 1'b0;
    mon_en = 1'b1;

    // Two 32-bit words.
    issue(32'h00A00093); issue(32'h00100113); drain();
    // Two c.li in one word.
    issue(32'h45014505); drain();
    // 32-bit instruction straddling a word boundary.
    issue(32'h00934505); push_all(1'b1);
    repeat (3) cycle(1'b0, 32'h0, 1'b0, 1'b1);
    issue(32'h0000000A); drain();

    // Redirect into an upper halfword.
    cycle(1'b1, 32'h0000_0102, 1'b0, 1'b0);
    issue(32'h4505FFFF); push_all(1'b0);
    repeat (2) cycle(1'b0, 32'h0, 1'b0, 1'b0);
    check("flush_level", 32'(level), 1);
    check("flush_pc", out_pc, 32'h0000_0102);
    check("flush_instr", out_instr, 32'h0000_4505);
    check("flush_compressed", 32'(out_compressed), 1);
    drain();

    // Fill to capacity under stall, then release while still pushing.
    cycle(1'b1, 32'h0000_0200, 1'b0, 1'b0);
    issue(32'h00A00093); issue(32'h00100113); issue(32'h45014505); issue(32'h00934505);
    push_all(1'b0);
    repeat (3) cycle(1'b0, 32'h0, 1'b0, 1'b0);
    check("full_level", 32'(level), DEPTH);
    check("full_in_ready", 32'(in_ready), 0);
    issue(32'h0000000A); issue(32'h00A00093); issue(32'h45014505); issue(32'h00100113);
    drain();

    // Asynchronous reset at level 5.
    cycle(1'b1, 32'h0000_0002, 1'b0, 1'b0);
    issue(32'h00A00093); issue(32'h00100113); issue(32'h45014505);
    push_all(1'b0);
    check("pre_reset_level", 32'(level), 5);
    #2 reset = 1'b1;
    #1;
    check("arst_level", 32'(level), 0);
    check("arst_out_valid", 32'(out_valid), 0);
    check("arst_out_pc", out_pc, RESET_PC);
    check("arst_out_instr", out_instr, NOP_INSTR);
    check("arst_in_ready", 32'(in_ready), 1);
    model_reset(RESET_PC, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Randomised traffic with redirects, stalls and PC wrap-around.
    rdy_pct = 100;
    for (int c = 0; c < 3000; c++) begin
      if (c % 32 == 0) begin
        case ($urandom_range(0, 2))
          0:       rdy_pct = 10;
          1:       rdy_pct = 50;
          default: rdy_pct = 100;
        endcase
      end
      if (w_q.size() < 3 && $urandom_range(0, 3) != 0) issue(rand_word());
      if ($urandom_range(0, 79) == 0) begin
        if ($urandom_range(0, 2) == 0) fpc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        else                           fpc = $urandom & 32'h0000_FFFF;
        cycle(1'b1, fpc, 1'b0, $urandom_range(0, 99) < rdy_pct);
      end else begin
        cycle(1'b0, 32'h0, $urandom_range(0, 3) != 0, $urandom_range(0, 99) < rdy_pct);
      end
    end
    drain();

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_align_queue.md
Name: fetch_align_queue

Overview:
- Parametrised instruction fetch buffer between program memory and the IF/ID register.
- Replaces the single-word, compressed-flag fetch path with a queue of halfword entries.
- Accepts aligned 32-bit fetch words and emits whole RV32IC instructions (16- or 32-bit) with their PC, including 32-bit instructions that straddle a word boundary.
- Supports redirect/flush from branch resolution.

Parameters:
- DEPTH_HW, 8: queue capacity in 16-bit halfword entries; power of two, at least 4.
- PC_WIDTH, 32: width of the PC.
- RESET_PC, 32'h0000_0000: head PC after reset.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  fetch word available.
- in_ready  out  1  queue can accept a fetch word this cycle.
- in_word  in  32  aligned fetch word; bits [15:0] are the lower-address halfword.
- flush  in  1  redirect: discard all contents.
- flush_pc  in  PC_WIDTH  new fetch PC; bit 0 is ignored.
- out_valid  out  1  complete instruction at head.
- out_ready  in  1  consumer (IF/ID) accepts the instruction.
- out_instr  out  32  instruction; a compressed instruction is zero-extended to {16'h0,hw}.
- out_pc  out  PC_WIDTH  PC of out_instr.
- out_compressed  out  1  head instruction is 16-bit.
- level  out  $clog2(DEPTH_HW)+1  occupied halfword count.

Behaviour:
- Reset (async, active-high):
  - queue empty: level=0, out_valid=0, in_ready=1.
  - head_pc=RESET_PC, skip_lo=0.
  - out_instr=32'h00000013 while out_valid=0.
- Storage: ring of DEPTH_HW halfwords with head/tail pointers that wrap modulo DEPTH_HW, plus a count register.
- Push:
  - in_ready = 1 when free entries ≥ (skip_lo ? 1 : 2), and flush=0.
  - An accepted word (in_valid & in_ready) enqueues in_word[15:0] then in_word[31:16].
  - If skip_lo=1, only in_word[31:16] is enqueued, and skip_lo clears.
- Head decode:
  - compressed = head_hw[1:0] != 2'b11.
  - out_valid = (compressed & level≥1) | (!compressed & level≥2).
  - out_instr = compressed ? {16'h0,hw0} : {hw1,hw0}.
  - Purely combinational from the queue registers: zero-cycle latency from storage to output.
- Pop:
  - out_valid & out_ready removes 1 (compressed) or 2 halfwords.
  - head_pc advances by 2 or 4; it wraps modulo 2^PC_WIDTH.
- Simultaneous push and pop in one cycle is legal. The next level = level + pushed − popped, with pushed and popped each in {0,1,2}.
- Full boundary: a push whose entries would exceed DEPTH_HW is impossible by construction of in_ready. Level exactly DEPTH_HW is reachable.
- Empty/partial boundary: a 32-bit instruction with only its low halfword queued keeps out_valid=0 until its high halfword arrives.
- Latency: a word pushed into an empty queue makes out_valid=1 on the next cycle. There is no bypass.
- Flush (synchronous, highest priority):
  - In the flush cycle, no push or pop takes effect; in_ready=0, and out_valid is still driven from the old contents.
  - Next cycle: level=0, head_pc={flush_pc[PC_WIDTH-1:1],1'b0}, skip_lo=flush_pc[1].
  - The first word accepted after flush must be the word containing flush_pc.
  - Flush overrides any simultaneous out_ready.
- Stall: out_ready=0 holds the head and all outputs stable. Pushes continue until in_ready drops.
- Reset mid-operation: immediate return to reset state, regardless of flush or handshakes.

Decomposition:
- Shared package (common):
  - halfword_t (logic [15:0]).
  - FAQ_DEPTH_HW default.
  - NOP_INSTR = 32'h00000013.
  - fetch_out_type struct {instr, pc, compressed} for the IF/ID register.
- Sub-module hw_ring_buffer:
  - Generic halfword ring with 0/1/2-entry push and pop per cycle.
  - Count and peek of the two head entries.
  - Synchronous clear.
- fetch_align_queue owns decode, head_pc, skip_lo and flush control.

Test Plan:
- Reset, then push 0x00A00093 and 0x00100113 (two 32-bit words) → out (0x00A00093, pc 0x0), then (0x00100113, pc 0x4); level returns to 0.
- Push 0x45014505 (two c.li) → out 0x00004505 at pc 0x0 with compressed=1, then 0x00004501 at pc 0x2.
- Straddle: push 0x00934505, then 0x0000000A → out 0x4505 at pc 0x0 (compressed); then 0x000A0093 at pc 0x2 (32-bit). out_valid=0 in the cycle after the first push, once 0x4505 has been consumed.
- Flush with flush_pc=0x102, then push 0x4505_FFFF → only 0x4505 is enqueued; out pc 0x102, compressed=1; level 1 before the pop.
- Hold out_ready=0 with DEPTH_HW=8 and push 4 words → in_ready=0 at level 8; outputs stable. Raise out_ready with one push per cycle → no loss or duplication, in order.
- Assert reset while level=5 mid-stream → level=0, out_valid=0, out_pc=RESET_PC immediately, with no clock edge needed.
